opcode_decode_stage: RTL and testbench

Registered, flow-controlled instruction-opcode decoder that replaces the purely combinational opcode decode in the fetch-to-execute path. It splits an OPW-bit opcode into a one-hot group field and, for groups selected by SUB_MASK, a one-hot sub-operation field. It flags illegal groups and passes the raw low bits through. A valid/ready handshake with a 2-entry skid buffer lets the execute stage stall without dropping opcodes, and saturating counters track decoded and illegal opcodes.

---
 rtl/opcode_decode_stage.sv | 106 ++++++++++
 tb/tb_opcode_decode_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/opcode_decode_stage.sv
// Registered opcode decoder with a valid/ready handshake, a 2-entry skid buffer and
// saturating statistics counters for decoded and illegal opcodes.
//
// buffer state (or_valid, sr_valid) | meaning
//   EMPTY (0,0)                     | nothing held, next accept goes straight to the output register
//   ONE   (1,0)                     | output register holds the oldest opcode
//   FULL  (1,1)                     | skid register holds a second opcode, in_ready is low
module opcode_decode_stage #(
  parameter int                 OPW          = 8,
  parameter int                 GW           = OPW / 2,
  parameter logic [(2**GW)-1:0] SUB_MASK     = 16'h9002,
  parameter logic [(2**GW)-1:0] ILLEGAL_MASK = 16'h0000,
  parameter int                 CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      in_opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(2**GW)-1:0]  out_group,
  output logic [3:0]          out_sub,
  output logic [OPW-GW-1:0]   out_raw,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    dec_count,
  output logic [CNT_W-1:0]    ill_count
);

  localparam int NG = 2**GW;
  localparam int RW = OPW - GW;

  typedef struct packed {
    logic [NG-1:0] grp;
    logic [3:0]    sub;
    logic [RW-1:0] raw;
    logic          ill;
  } payload_t;

  payload_t      dec_p;
  payload_t      or_p;
  payload_t      sr_p;
  logic          or_valid;
  logic          sr_valid;
  logic [GW-1:0] grp_idx;
  logic          accept;
  logic          consume;
  logic          or_load;

  always_comb begin
    grp_idx   = in_opcode[OPW-1:RW];
    dec_p     = '0;
    dec_p.grp = {{(NG-1){1'b0}}, 1'b1} << grp_idx;
    dec_p.sub = SUB_MASK[grp_idx] ? (4'b0001 << in_opcode[1:0]) : 4'b0000;
    dec_p.raw = in_opcode[RW-1:0];
    dec_p.ill = ILLEGAL_MASK[grp_idx];
  end

  assign in_ready = ~sr_valid & ~rst;
  // A flushed cycle drops whatever is presented on the input.
  assign accept   = in_valid & in_ready & ~flush;
  assign consume  = or_valid & out_ready;
  assign or_load  = ~or_valid | consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid  <= 1'b0;
      sr_valid  <= 1'b0;
      or_p      <= '0;
      sr_p      <= '0;
      dec_count <= '0;
      ill_count <= '0;
    end else begin
      if (consume) begin
        if (dec_count != {CNT_W{1'b1}}) dec_count <= dec_count + 1'b1;
        if (or_p.ill && (ill_count != {CNT_W{1'b1}})) ill_count <= ill_count + 1'b1;
      end
      if (flush) begin
        or_valid <= 1'b0;
        sr_valid <= 1'b0;
      end else if (or_load) begin
        if (sr_valid) begin
          or_p     <= sr_p;
          or_valid <= 1'b1;
          sr_valid <= 1'b0;
        end else if (accept) begin
          or_p     <= dec_p;
          or_valid <= 1'b1;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        sr_p     <= dec_p;
        sr_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = or_valid;
  assign out_group   = or_p.grp;
  assign out_sub     = or_p.sub;
  assign out_raw     = or_p.raw;
  assign out_illegal = or_p.ill;

endmodule

// File: tb/tb_opcode_decode_stage.sv
// Bench for opcode_decode_stage: directed scenarios plus random traffic, all checked
// against a FIFO-of-opcodes reference model.
module tb_opcode_decode_stage;

  localparam int          OPW      = 8;
  localparam int          RW       = 4;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = 15;
  localparam logic [15:0] SUB_M    = 16'h9002;
  localparam logic [15:0] ILL_M    = 16'h0400;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_opcode;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_group;
  logic [3:0]      out_sub;
  logic [3:0]      out_raw;
  logic            out_illegal;
  logic [CNT_W-1:0] dec_count;
  logic [CNT_W-1:0] ill_count;

  opcode_decode_stage #(
    .OPW(OPW), .SUB_MASK(SUB_M), .ILLEGAL_MASK(ILL_M), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_group(out_group), .out_sub(out_sub), .out_raw(out_raw),
    .out_illegal(out_illegal), .dec_count(dec_count), .ill_count(ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int         m_dec = 0;
  int         m_ill = 0;
  bit         post_rst = 0;
  bit         last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int grp_of(input logic [7:0] op);
    return int'(op) / (2**RW);
  endfunction

  function automatic logic [31:0] ref_group(input logic [7:0] op);
    return 32'd1 << grp_of(op);
  endfunction

  function automatic logic [31:0] ref_sub(input logic [7:0] op);
    if (((SUB_M >> grp_of(op)) & 16'd1) != 16'd0) return 32'd1 << (int'(op) % 4);
    return 32'd0;
  endfunction

  function automatic logic ref_ill(input logic [7:0] op);
    return ((ILL_M >> grp_of(op)) & 16'd1) != 16'd0;
  endfunction

  // One clock cycle: drive inputs, advance the model, then check outputs after the edge.
  task automatic step(input logic v, input logic [7:0] op, input logic ordy,
                      input logic fl, input logic r);
    bit cons;
    in_valid  = v;
    in_opcode = op;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    check("in_ready", 32'(in_ready), (!r && q.size() < 2) ? 32'd1 : 32'd0);
    last_acc = 0;
    if (r) begin
      q.delete();
      m_dec    = 0;
      m_ill    = 0;
      post_rst = 1;
    end else begin
      cons     = (q.size() > 0) && ordy;
      last_acc = v && (q.size() < 2) && !fl;
      if (cons) begin
        if (m_dec < CNT_MAX) m_dec++;
        if (ref_ill(q[0]) && m_ill < CNT_MAX) m_ill++;
        popped.push_back(q[0]);
        void'(q.pop_front());
      end
      if (fl) q.delete();
      else if (last_acc) q.push_back(op);
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) begin
      post_rst = 0;
      check("out_group", 32'(out_group), ref_group(q[0]));
      check("out_sub", 32'(out_sub), ref_sub(q[0]));
      check("out_raw", 32'(out_raw), 32'(int'(q[0]) % (2**RW)));
      check("out_illegal", 32'(out_illegal), 32'(ref_ill(q[0])));
    end else if (post_rst) begin
      check("rst_payload", {out_group, out_sub, out_raw, out_illegal}, 32'd0);
    end
    check("dec_count", 32'(dec_count), 32'(m_dec));
    check("ill_count", 32'(ill_count), 32'(m_ill));
  endtask

  int saved_dec;
  int saved_ill;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = 8'h00; out_ready = 1'b0;

    // reset, then a single opcode 8'h00
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h00, 1, 0, 0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_group", 32'(out_group), 32'h0001);
    check("t1_sub", 32'(out_sub), 32'h0);
    step(0, 8'h00, 1, 0, 0);
    check("t1_dec", 32'(dec_count), 32'd1);

    // back-to-back stream
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h12, 1, 0, 0);
    check("t2_g12", 32'(out_group), 32'h0002);
    check("t2_s12", 32'(out_sub), 32'h4);
    step(1, 8'hC1, 1, 0, 0);
    check("t2_gC1", 32'(out_group), 32'h1000);
    check("t2_sC1", 32'(out_sub), 32'h2);
    step(1, 8'hF3, 1, 0, 0);
    check("t2_gF3", 32'(out_group), 32'h8000);
    check("t2_sF3", 32'(out_sub), 32'h8);
    step(0, 8'h00, 1, 0, 0);
    check("t2_dec", 32'(dec_count), 32'd3);

    // stall with skid buffer
    step(0, 8'h00, 1, 0, 1);
    popped.delete();
    step(1, 8'h30, 0, 0, 0);
    step(1, 8'h41, 0, 0, 0);
    check("t3_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h52, 0, 0, 0);
      check("t3_hold", {out_group, out_raw}, {16'h0008, 4'h0});
    end
    for (int i = 0; i < 6 && !last_acc; i++) step(1, 8'h52, 1, 0, 0);
    check("t3_acc52", 32'(last_acc), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    check("t3_order", (popped.size() == 3) ? {8'h0, popped[0], popped[1], popped[2]} : 32'hFFFF_FFFF,
          32'h0030_4152);

    // illegal group
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'hA7, 1, 0, 0);
    check("t4_ill0", 32'(out_illegal), 32'd1);
    step(1, 8'h25, 1, 0, 0);
    check("t4_ill1", 32'(out_illegal), 32'd0);
    step(1, 8'hAF, 1, 0, 0);
    check("t4_ill2", 32'(out_illegal), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    check("t4_illc", 32'(ill_count), 32'd2);
    check("t4_decc", 32'(dec_count), 32'd3);

    // counter saturation
    step(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("t5_sat", 32'(dec_count), 32'hF);

    // flush while full
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h05, 1, 0, 0);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    saved_dec = int'(dec_count);
    saved_ill = int'(ill_count);
    popped.delete();
    step(1, 8'h77, 0, 1, 0);
    check("t6_fl_valid", 32'(out_valid), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    check("t6_fl_dec", 32'(dec_count), 32'(saved_dec));
    check("t6_fl_ill", 32'(ill_count), 32'(saved_ill));
    check("t6_no77", 32'(popped.size()), 32'd0);

    // same scenario with reset
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h77, 0, 0, 1);
    check("t6_rs_valid", 32'(out_valid), 32'd0);
    check("t6_rs_dec", 32'(dec_count), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    check("t6_rs_valid2", 32'(out_valid), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 47) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
